alu_decode_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational ALU control decoder. It registers the decoded `alu_control` and operand-read enables behind a valid/ready handshake. It tracks the destination registers of the last `FWD_DEPTH` issued instructions and generates operand forwarding selects. It sits between instruction fetch/decode and the ALU execute stage.

---
 rtl/alu_decode_pipe.sv | 194 +++++++++++++++++++
 tb/tb_alu_decode_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_pipe.sv
// Pipelined ALU control decoder: registered decode bundle behind a valid/ready handshake,
// with operand-forwarding selects derived from the last FWD_DEPTH accepted destinations.
// Optional macro ALU_DEC_ILLEGAL_TRAP_EN: unused opcodes set a sticky illegal_op and are dropped.
module alu_decode_pipe #(
    parameter int REG_ADDR_W = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op_code,
    input  logic [REG_ADDR_W-1:0] ra,
    input  logic [REG_ADDR_W-1:0] rb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  se1,
    output logic                  se2,
    output logic [1:0]            se3,
    output logic [1:0]            se4,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic                  illegal_op
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_MOV   = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0011,
        OP_AND   = 4'b0100,
        OP_OR    = 4'b0101,
        OP_GRP_C = 4'b0110,
        OP_GRP_U = 4'b1000
    } opcode_e;

    // Forwarding history; index 0 is the youngest accepted instruction.
    logic                  hist_v [FWD_DEPTH];
    logic [REG_ADDR_W-1:0] hist_a [FWD_DEPTH];

    logic [3:0] d_ctrl;
    logic       d_rd_a;
    logic       d_rd_b;
    logic       d_wr;
    logic       d_dst_b;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [1:0] sub_op;
    logic       sub_ok;
    logic       accept;
    logic       take;

    // Groups 0110/1000 reuse ra as a sub-op; wider address fields must keep the upper bits clear.
    generate
        if (REG_ADDR_W >= 3) begin : g_sub_wide
            assign sub_op = ra[1:0];
            assign sub_ok = ~|ra[REG_ADDR_W-1:2];
        end else if (REG_ADDR_W == 2) begin : g_sub_exact
            assign sub_op = ra;
            assign sub_ok = 1'b1;
        end else begin : g_sub_narrow
            assign sub_op = {1'b0, ra};
            assign sub_ok = 1'b1;
        end
    endgenerate

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        d_ctrl  = 4'd0;
        d_rd_a  = 1'b0;
        d_rd_b  = 1'b0;
        d_wr    = 1'b0;
        d_dst_b = 1'b0;
        case (op_code)
            OP_MOV: begin
                d_ctrl = 4'd1;
                d_rd_b = 1'b1;
                d_wr   = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                d_ctrl = op_code;
                d_rd_a = 1'b1;
                d_rd_b = 1'b1;
                d_wr   = 1'b1;
            end
            OP_GRP_C: begin
                if (sub_ok) begin
                    d_ctrl = 4'd6 + {2'b00, sub_op};
                    // RLC/RRC rotate rb in place; SETC/CLRC only touch the carry flag.
                    if (!sub_op[1]) begin
                        d_rd_b  = 1'b1;
                        d_wr    = 1'b1;
                        d_dst_b = 1'b1;
                    end
                end
            end
            OP_GRP_U: begin
                if (sub_ok) begin
                    d_ctrl  = 4'd10 + {2'b00, sub_op};
                    d_rd_b  = 1'b1;
                    d_wr    = 1'b1;
                    d_dst_b = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        sel_a = 2'b00;
        sel_b = 2'b00;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (hist_v[k] && hist_a[k] == ra) sel_a = 2'(k + 1);
            if (hist_v[k] && hist_a[k] == rb) sel_b = 2'(k + 1);
        end
        if (!d_rd_a) sel_a = 2'b00;
        if (!d_rd_b) sel_b = 2'b00;
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

`ifdef ALU_DEC_ILLEGAL_TRAP_EN
    logic op_unused;

    assign op_unused = !(op_code inside {OP_NOP, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
                                         OP_GRP_C, OP_GRP_U})
                       || ((op_code == OP_GRP_C || op_code == OP_GRP_U) && !sub_ok);
    // Trapped opcodes are consumed from the input but never reach execute or the history.
    assign take = accept && !op_unused;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_op <= 1'b0;
        end else if (accept && op_unused) begin
            illegal_op <= 1'b1;
        end
    end
`else
    assign take       = accept;
    assign illegal_op = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            alu_control <= '0;
            se1         <= 1'b0;
            se2         <= 1'b0;
            se3         <= 2'b00;
            se4         <= 2'b00;
            wb_en       <= 1'b0;
            wb_addr     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (take) begin
            out_valid   <= 1'b1;
            alu_control <= ALU_CTRL_W'(d_ctrl);
            se1         <= d_rd_a;
            se2         <= d_rd_b;
            se3         <= sel_b;
            se4         <= sel_a;
            wb_en       <= d_wr;
            wb_addr     <= d_wr ? (d_dst_b ? rb : ra) : '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // NOTE: history is reset because its valid bits gate forwarding; a stale hit would be wrong.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                hist_v[k] <= 1'b0;
                hist_a[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < FWD_DEPTH; k++) hist_v[k] <= 1'b0;
        end else if (take) begin
            for (int k = FWD_DEPTH - 1; k > 0; k--) begin
                hist_v[k] <= hist_v[k-1];
                hist_a[k] <= hist_a[k-1];
            end
            hist_v[0] <= d_wr;
            hist_a[0] <= d_dst_b ? rb : ra;
        end
    end

endmodule

// File: tb/tb_alu_decode_pipe.sv
// Scoreboard bench for alu_decode_pipe (default parameters): directed instructions push
// hand-computed bundles; a negedge monitor pops and compares each transferred bundle.
module tb_alu_decode_pipe;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       se1;
        logic       se2;
        logic [1:0] se3;
        logic [1:0] se4;
        logic       wb_en;
        logic [1:0] wb_addr;
    } bund_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op_code;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_control;
    logic       se1;
    logic       se2;
    logic [1:0] se3;
    logic [1:0] se4;
    logic       wb_en;
    logic [1:0] wb_addr;
    logic       illegal_op;

    int    total = 0;
    int    bad   = 0;
    bund_t sb[$];

    always #5 clk = ~clk;

    alu_decode_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_code    (op_code),
        .ra         (ra),
        .rb         (rb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_control(alu_control),
        .se1        (se1),
        .se2        (se2),
        .se3        (se3),
        .se4        (se4),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .illegal_op (illegal_op)
    );

    function automatic bund_t mk(input int ctrl, input bit s1, input bit s2, input int s3,
                                 input int s4, input bit wb, input int addr);
        bund_t b;
        b.ctrl    = 4'(ctrl);
        b.se1     = s1;
        b.se2     = s2;
        b.se3     = 2'(s3);
        b.se4     = 2'(s4);
        b.wb_en   = wb;
        b.wb_addr = 2'(addr);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Present one instruction, wait (bounded) for in_ready, and queue its expected bundle.
    task automatic issue(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                         input bund_t exp, input bit produces);
        int waited;
        waited = 0;
        @(negedge clk);
        op_code  = op;
        ra       = a;
        rb       = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout op=%b in_ready=%b required=1", op, in_ready);
            in_valid = 1'b0;
            return;
        end
        if (produces) sb.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: a bundle transfers at the next rising edge when out_valid && out_ready.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            bund_t got;
            bund_t exp;
            got = {alu_control, se1, se2, se3, se4, wb_en, wb_addr};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_bundle actual=%h required=none", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL bundle actual ctrl=%0d se1=%b se2=%b se3=%b se4=%b wb=%b/%0d required ctrl=%0d se1=%b se2=%b se3=%b se4=%b wb=%b/%0d",
                             got.ctrl, got.se1, got.se2, got.se3, got.se4, got.wb_en, got.wb_addr,
                             exp.ctrl, exp.se1, exp.se2, exp.se3, exp.se4, exp.wb_en, exp.wb_addr);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        op_code   = 4'b0010;
        ra        = 2'd1;
        rb        = 2'd2;
        out_ready = 1'b1;

        // Reset held with an instruction offered: nothing may load.
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_alu_control", 32'(alu_control), 0);
        check("rst_se", {28'd0, se1, se2, se3 != 0, se4 != 0}, 0);
        check("rst_wb", {29'd0, wb_en, wb_addr}, 0);
        check("rst_illegal", 32'(illegal_op), 0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_out_valid", 32'(out_valid), 0);

        // Back-to-back stream with out_ready=1; selects hand-derived from the history.
        issue(4'b0010, 2'd1, 2'd2, mk(2, 1, 1, 0, 0, 1, 1), 1);   // ADD r1,r2
        issue(4'b0011, 2'd1, 2'd3, mk(3, 1, 1, 0, 1, 1, 1), 1);   // SUB r1,r3: ra hits hist0
        issue(4'b0001, 2'd2, 2'd1, mk(1, 0, 1, 1, 0, 1, 2), 1);   // MOV r2<-r1
        issue(4'b0000, 2'd3, 2'd3, mk(0, 0, 0, 0, 0, 0, 0), 1);   // NOP
        issue(4'b1000, 2'd0, 2'd2, mk(10, 0, 1, 2, 0, 1, 2), 1);  // NOT r2: hist1
        issue(4'b0100, 2'd2, 2'd2, mk(4, 1, 1, 1, 1, 1, 2), 1);   // AND r2,r2
        issue(4'b0101, 2'd3, 2'd0, mk(5, 1, 1, 0, 0, 1, 3), 1);   // OR r3,r0
        issue(4'b0110, 2'd0, 2'd2, mk(6, 0, 1, 2, 0, 1, 2), 1);   // RLC r2
        issue(4'b0110, 2'd2, 2'd3, mk(8, 0, 0, 0, 0, 0, 0), 1);   // SETC
        issue(4'b0110, 2'd3, 2'd2, mk(9, 0, 0, 0, 0, 0, 0), 1);   // CLRC
        issue(4'b0110, 2'd1, 2'd2, mk(7, 0, 1, 0, 0, 1, 2), 1);   // RRC r2: history all invalid
        issue(4'b1000, 2'd1, 2'd2, mk(11, 0, 1, 1, 0, 1, 2), 1);  // NEG r2
        issue(4'b1000, 2'd3, 2'd0, mk(13, 0, 1, 0, 0, 1, 0), 1);  // DEC r0
        issue(4'b1000, 2'd2, 2'd2, mk(12, 0, 1, 2, 0, 1, 2), 1);  // INC r2

        // Stall: execute refuses INC for three cycles while ADD r2,r0 waits at the input.
        out_ready = 1'b0;
        fork
            issue(4'b0010, 2'd2, 2'd0, mk(2, 1, 1, 2, 1, 1, 2), 1);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 0);
                    check("stall_out_valid", 32'(out_valid), 1);
                    check("stall_hold_ctrl", 32'(alu_control), 12);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        // Flush with a simultaneous offer: no accept, history cleared.
        issue(4'b0001, 2'd1, 2'd3, mk(1, 0, 1, 0, 0, 1, 1), 1);   // MOV r1<-r3
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        op_code  = 4'b0010;
        ra       = 2'd1;
        rb       = 2'd1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 0);
        issue(4'b0010, 2'd1, 2'd1, mk(2, 1, 1, 0, 0, 1, 1), 1);   // ADD r1,r1: no forward
        issue(4'b0011, 2'd1, 2'd1, mk(3, 1, 1, 1, 1, 1, 1), 1);   // SUB r1,r1: hist0 again

        // Unused opcode 1111.
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
        issue(4'b1111, 2'd1, 2'd1, mk(0, 0, 0, 0, 0, 0, 0), 0);
        @(negedge clk);
        check("illegal_set", 32'(illegal_op), 1);
        check("illegal_dropped", 32'(out_valid), 0);
        issue(4'b0010, 2'd1, 2'd0, mk(2, 1, 1, 0, 1, 1, 1), 1);   // history not shifted
`else
        issue(4'b1111, 2'd1, 2'd1, mk(0, 0, 0, 0, 0, 0, 0), 1);
        check("illegal_tied", 32'(illegal_op), 0);
        issue(4'b0010, 2'd1, 2'd0, mk(2, 1, 1, 0, 2, 1, 1), 1);   // invalid entry pushed
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);
        check("final_out_valid", 32'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
